// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-Lite to APB bridges.
//   bridge_state_e : bridge FSM encoding (idle, APB setup, APB access)
//   HTRANS_*       : AHB transfer type codes
//   clog2()        : slot-index width for a power-of-two slot count
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } bridge_state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/ahb2apb_bridge_if.sv
// Bus bundle between an AHB-Lite master side and an APB slave side of the bridge.
//   slave modport  : the bridge's view (AHB inputs, APB outputs, APB read data in)
//   master modport : the surrounding system's view (the opposite directions)
// APB_PREADY_EN adds apb_pready (one bit per slot) for wait-stated APB slaves.
interface ahb2apb_bridge_if #(
    parameter int unsigned NSLV = 4
);
    logic                 ahb_hsel;
    logic [31:0]          ahb_haddr;
    logic [1:0]           ahb_htrans;
    logic                 ahb_hwrite;
    logic [31:0]          ahb_hwdata;
    logic                 ahb_hready;
    logic                 ahb_hreadyout;
    logic                 ahb_hresp;
    logic [31:0]          ahb_hrdata;
    logic [NSLV-1:0]      apb_psel;
    logic                 apb_penable;
    logic                 apb_pwrite;
    logic [31:0]          apb_paddr;
    logic [31:0]          apb_pwdata;
    logic [NSLV*32-1:0]   apb_prdata;
`ifdef APB_PREADY_EN
    logic [NSLV-1:0]      apb_pready;
`endif

    modport slave (
        input  ahb_hsel, ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hwdata, ahb_hready, apb_prdata,
`ifdef APB_PREADY_EN
        input  apb_pready,
`endif
        output ahb_hreadyout, ahb_hresp, ahb_hrdata,
        output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );

    modport master (
        output ahb_hsel, ahb_haddr, ahb_htrans, ahb_hwrite, ahb_hwdata, ahb_hready, apb_prdata,
`ifdef APB_PREADY_EN
        output apb_pready,
`endif
        input  ahb_hreadyout, ahb_hresp, ahb_hrdata,
        input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata
    );

endinterface

// File: rtl/apb_rdata_mux.sv
// Slot-indexed APB read-data selector.
//   prdata : flattened read data, slot k at bits [32k+31:32k]
//   slot   : slot index
//   rdata  : selected 32-bit word
module apb_rdata_mux #(
    parameter int unsigned NSLV   = 4,
    parameter int unsigned SLOT_W = 2
) (
    input  logic [NSLV*32-1:0] prdata,
    input  logic [SLOT_W-1:0]  slot,
    output logic [31:0]        rdata
);

    always_comb begin
        rdata = '0;
        for (int k = 0; k < int'(NSLV); k++) begin
            if (slot == SLOT_W'(k)) begin
                rdata = prdata[32*k +: 32];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge, single clock domain.
//   apb_pclk  : shared AHB/APB clock
//   apb_prstn : asynchronous active-low reset
//   bus       : ahb2apb_bridge_if.slave (AHB address/data phase in, APB master out)
// Each accepted NONSEQ/SEQ transfer becomes one APB SETUP + ACCESS; psel always returns low
// for at least one cycle between transfers.
// Define APB_PREADY_EN to stretch ACCESS until apb_pready[slot] is high.
module ahb2apb_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned NSLV     = 4,
    parameter int unsigned SLOT_LSB = 12
) (
    input  logic            apb_pclk,
    input  logic            apb_prstn,
    ahb2apb_bridge_if.slave bus
);

    localparam int unsigned SLOT_W = clog2(NSLV);

    bridge_state_e     state_q;
    logic [SLOT_W-1:0] slot_q;
    logic [NSLV-1:0]   psel_q;
    logic              penable_q;
    logic              pwrite_q;
    logic [31:0]       paddr_q;
    logic [31:0]       pwdata_q;
    logic [31:0]       hrdata_q;
    logic              hreadyout_q;

    logic              accept;
    logic              access_done;
    logic [SLOT_W-1:0] slot_next;
    logic [31:0]       slot_rdata;
    logic              unused_htrans;

    // htrans[1] alone separates NONSEQ/SEQ from IDLE/BUSY.
    assign unused_htrans = bus.ahb_htrans[0];
    assign accept    = bus.ahb_hsel & bus.ahb_htrans[1] & bus.ahb_hready & (state_q == StIdle);
    assign slot_next = bus.ahb_haddr[SLOT_LSB +: SLOT_W];

`ifdef APB_PREADY_EN
    assign access_done = bus.apb_pready[slot_q];
`else
    assign access_done = 1'b1;
`endif

    apb_rdata_mux #(
        .NSLV  (NSLV),
        .SLOT_W(SLOT_W)
    ) u_rdata_mux (
        .prdata(bus.apb_prdata),
        .slot  (slot_q),
        .rdata (slot_rdata)
    );

    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        state_q     <= StSetup;
                        slot_q      <= slot_next;
                        paddr_q     <= bus.ahb_haddr;
                        pwrite_q    <= bus.ahb_hwrite;
                        psel_q      <= NSLV'(1) << slot_next;
                        hreadyout_q <= 1'b0;
                    end
                end
                StSetup: begin
                    // First data-phase cycle: hwdata is valid now.
                    pwdata_q  <= bus.ahb_hwdata;
                    penable_q <= 1'b1;
                    state_q   <= StAccess;
                end
                StAccess: begin
                    if (access_done) begin
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        hreadyout_q <= 1'b1;
                        if (!pwrite_q) begin
                            hrdata_q <= slot_rdata;
                        end
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // During SETUP the data register has not been loaded yet, so forward hwdata directly.
    assign bus.apb_pwdata    = (state_q == StSetup) ? bus.ahb_hwdata : pwdata_q;
    assign bus.apb_psel      = psel_q;
    assign bus.apb_penable   = penable_q;
    assign bus.apb_pwrite    = pwrite_q;
    assign bus.apb_paddr     = paddr_q;
    assign bus.ahb_hrdata    = hrdata_q;
    assign bus.ahb_hreadyout = hreadyout_q;
    assign bus.ahb_hresp     = 1'b0;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Testbench for ahb2apb_bridge (NSLV=4, SLOT_LSB=12). Directed cases followed by random
// transfers; an APB-side monitor compares every APB transfer against the queue of transfers
// the AHB driver issued. Honours APB_PREADY_EN for wait-stated accesses.
module tb_ahb2apb_bridge;
    import apb_bridge_pkg::*;

    localparam int unsigned NSLV     = 4;
    localparam int unsigned SLOT_LSB = 12;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;
    } xfer_t;

    logic apb_pclk  = 1'b0;
    logic apb_prstn = 1'b1;

    always #5 apb_pclk = ~apb_pclk;

    ahb2apb_bridge_if #(.NSLV(NSLV)) bus ();

    ahb2apb_bridge #(
        .NSLV    (NSLV),
        .SLOT_LSB(SLOT_LSB)
    ) dut (
        .apb_pclk (apb_pclk),
        .apb_prstn(apb_prstn),
        .bus      (bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          pushed       = 0;
    int          setups_seen  = 0;
    xfer_t       exp_q[$];
    logic [31:0] prdata_model [NSLV];
    logic [31:0] last_rdata   = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int slot_of(input logic [31:0] addr);
        return int'((addr >> SLOT_LSB) % NSLV);
    endfunction

    function automatic logic [NSLV-1:0] psel_of(input logic [31:0] addr);
        logic [NSLV-1:0] one;
        one = 1;
        return one << slot_of(addr);
    endfunction

    task automatic drive_prdata();
        for (int k = 0; k < int'(NSLV); k++) begin
            bus.apb_prdata[32*k +: 32] = prdata_model[k];
        end
    endtask

    task automatic randomize_prdata();
        for (int k = 0; k < int'(NSLV); k++) begin
            prdata_model[k] = $urandom;
        end
        drive_prdata();
    endtask

    task automatic tick();
        @(posedge apb_pclk);
        #1;
    endtask

    task automatic bus_idle();
        bus.ahb_hsel   = 1'b0;
        bus.ahb_htrans = HTRANS_IDLE;
        bus.ahb_hready = 1'b1;
    endtask

    // Starts at #1 after an edge with the bridge idle; ends in the idle cycle after completion
    // (plus gap idle cycles), so gap=0 gives a back-to-back address phase.
    task automatic xfer(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                        input int waits, input int gap);
        xfer_t t;
        int    cnt;
        int    acc;
        int    s;
        s = slot_of(addr);
        t.addr  = addr;
        t.write = write;
        t.wdata = wdata;
        t.waits = waits;
        exp_q.push_back(t);
        pushed++;
        bus.ahb_hsel   = 1'b1;
        bus.ahb_htrans = ($urandom_range(0, 1) == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        bus.ahb_haddr  = addr;
        bus.ahb_hwrite = write;
        bus.ahb_hready = 1'b1;
        tick();
        // Scramble the address-phase inputs so only latched values can reach the APB side.
        bus_idle();
        bus.ahb_haddr  = $urandom;
        bus.ahb_hwrite = 1'($urandom_range(0, 1));
        bus.ahb_hwdata = wdata;
        check("accept_hreadyout", bus.ahb_hreadyout, 0);
        cnt = 0;
        acc = 0;
        while (bus.ahb_hreadyout !== 1'b1 && cnt < 40) begin
`ifdef APB_PREADY_EN
            if (bus.apb_penable) acc++;
            bus.apb_pready = (bus.apb_penable && acc > waits) ? '1 : ~psel_of(addr);
`endif
            tick();
            cnt++;
        end
        check("busy_cycles", cnt, 2 + waits);
        check("idle_psel", bus.apb_psel, 0);
        check("idle_penable", bus.apb_penable, 0);
        if (!write) last_rdata = prdata_model[s];
        check("hrdata", bus.ahb_hrdata, last_rdata);
        repeat (gap) tick();
    endtask

    // APB monitor: checks each transfer's SETUP and ACCESS cycles against the issued queue.
    initial begin
        logic [NSLV-1:0] prev_psel;
        xfer_t           cur;
        bit              active;
        int              access_cycles;
        prev_psel     = '0;
        active        = 1'b0;
        access_cycles = 0;
        forever begin
            @(negedge apb_pclk);
            if (!apb_prstn) begin
                prev_psel = '0;
                active    = 1'b0;
            end else begin
                if (bus.apb_psel != 0 && prev_psel == 0) begin
                    check("setup_penable", bus.apb_penable, 0);
                    if (exp_q.size() == 0) begin
                        check("setup_expected", exp_q.size(), 1);
                    end else begin
                        cur           = exp_q.pop_front();
                        active        = 1'b1;
                        access_cycles = 0;
                        setups_seen++;
                        check("setup_psel", bus.apb_psel, psel_of(cur.addr));
                        check("setup_paddr", bus.apb_paddr, cur.addr);
                        check("setup_pwrite", bus.apb_pwrite, cur.write);
                        check("setup_pwdata", bus.apb_pwdata, cur.wdata);
                    end
                end else if (bus.apb_psel != 0 && active) begin
                    access_cycles++;
                    check("access_penable", bus.apb_penable, 1);
                    check("access_psel", bus.apb_psel, psel_of(cur.addr));
                    check("access_paddr", bus.apb_paddr, cur.addr);
                    check("access_pwrite", bus.apb_pwrite, cur.write);
                    check("access_pwdata", bus.apb_pwdata, cur.wdata);
                    check("access_hreadyout", bus.ahb_hreadyout, 0);
                end else if (bus.apb_psel == 0 && prev_psel != 0 && active) begin
                    check("access_cycles", access_cycles, cur.waits + 1);
                    active = 1'b0;
                end
                if (bus.apb_psel == 0) check("psel_low_penable", bus.apb_penable, 0);
                prev_psel = bus.apb_psel;
            end
        end
    end

    initial begin
        int waits;
        bus_idle();
        bus.ahb_haddr  = '0;
        bus.ahb_hwrite = 1'b0;
        bus.ahb_hwdata = '0;
`ifdef APB_PREADY_EN
        bus.apb_pready = '1;
`endif
        randomize_prdata();
        #1 apb_prstn = 1'b0;
        #1;
        check("rst_psel", bus.apb_psel, 0);
        check("rst_penable", bus.apb_penable, 0);
        check("rst_pwrite", bus.apb_pwrite, 0);
        check("rst_paddr", bus.apb_paddr, 0);
        check("rst_pwdata", bus.apb_pwdata, 0);
        check("rst_hrdata", bus.ahb_hrdata, 0);
        check("rst_hreadyout", bus.ahb_hreadyout, 1);
        check("rst_hresp", bus.ahb_hresp, 0);
        repeat (2) @(posedge apb_pclk);
        #1 apb_prstn = 1'b1;
        tick();

        // Directed: write to slot 1, read from slot 2, back-to-back reads to the same slot.
        xfer(32'h0000_1000, 1'b1, 32'h0000_0041, 0, 1);
        prdata_model[2] = 32'h0000_0009;
        drive_prdata();
        xfer(32'h0000_2004, 1'b0, $urandom, 0, 1);
        xfer(32'h0000_1000, 1'b0, $urandom, 0, 0);
        xfer(32'h0000_1000, 1'b0, $urandom, 0, 1);

        // Transfers that must be ignored.
        bus.ahb_hsel   = 1'b1;
        bus.ahb_haddr  = 32'h0000_3000;
        bus.ahb_htrans = HTRANS_BUSY;
        tick();
        check("busy_psel", bus.apb_psel, 0);
        check("busy_hreadyout", bus.ahb_hreadyout, 1);
        bus.ahb_htrans = HTRANS_NONSEQ;
        bus.ahb_hready = 1'b0;
        tick();
        check("nohready_psel", bus.apb_psel, 0);
        check("nohready_hreadyout", bus.ahb_hreadyout, 1);
        bus_idle();
        tick();
        check("ignored_psel", bus.apb_psel, 0);

        // Reset asserted during ACCESS aborts the transfer without a clock edge.
        exp_q.push_back('{32'h0000_2008, 1'b1, 32'hdead_beef, 0});
        pushed++;
        bus.ahb_hsel   = 1'b1;
        bus.ahb_htrans = HTRANS_NONSEQ;
        bus.ahb_haddr  = 32'h0000_2008;
        bus.ahb_hwrite = 1'b1;
        tick();
        bus_idle();
        bus.ahb_hwdata = 32'hdead_beef;
`ifdef APB_PREADY_EN
        bus.apb_pready = '0;
`endif
        tick();
        check("pre_abort_penable", bus.apb_penable, 1);
        #2 apb_prstn = 1'b0;
        #1;
        check("abort_psel", bus.apb_psel, 0);
        check("abort_penable", bus.apb_penable, 0);
        check("abort_hreadyout", bus.ahb_hreadyout, 1);
        last_rdata = '0;
        @(posedge apb_pclk);
        #1 apb_prstn = 1'b1;
        tick();
        xfer(32'h0000_3010, 1'b0, $urandom, 0, 1);

`ifdef APB_PREADY_EN
        xfer(32'h0000_1000, 1'b1, 32'h0000_0055, 5, 1);
`endif

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            randomize_prdata();
`ifdef APB_PREADY_EN
            waits = $urandom_range(0, 3);
`else
            waits = 0;
`endif
            xfer($urandom, 1'($urandom_range(0, 1)), $urandom, waits, $urandom_range(0, 2));
        end

        repeat (2) tick();
        check("apb_transfers", setups_seen, pushed);
        check("queue_drained", exp_q.size(), 0);
        check("hresp", bus.ahb_hresp, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
